// File: rtl/stream_deserializer_pkg.sv
// Shared helpers for the stream deserializer: beat-completion rule used by the packer.
package stream_deserializer_pkg;

    // A beat closes the current word when it fills the last lane or carries the row marker.
    function automatic logic beat_completes(input logic lane_at_end, input logic last_beat);
        return lane_at_end | last_beat;
    endfunction

endpackage

// File: rtl/stream_deserializer.sv
// Packs RATIO narrow input beats into one wide output word; last_in flushes a partial word early.
module stream_deserializer
    import stream_deserializer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH-1:0]           data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic                          last_in,
    output logic [IN_WIDTH*RATIO-1:0]     data_out,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic                          last_out,
    output logic [$clog2(RATIO+1)-1:0]    count_out
);

    localparam int LANE_W  = $clog2(RATIO);
    localparam int COUNT_W = $clog2(RATIO+1);
    localparam int OUT_W   = IN_WIDTH * RATIO;

    logic [LANE_W-1:0] lane_r;
    logic [OUT_W-1:0]  asm_r;
    logic [OUT_W-1:0]  word_s;
    logic              accept_s;
    logic              last_lane_s;
    logic              complete_s;

    // Combinational so a consumed word frees the slot in the same cycle; the skid buffer downstream breaks the path.
    assign ready_in    = !valid_out || ready_out;
    assign accept_s    = valid_in && ready_in;
    assign last_lane_s = (lane_r == LANE_W'(RATIO - 1));
    assign complete_s  = accept_s && beat_completes(last_lane_s, last_in);

    // Assembly contents with the incoming beat dropped into the current lane; upper lanes stay zero.
    always_comb begin
        word_s = asm_r;
        word_s[int'(lane_r)*IN_WIDTH +: IN_WIDTH] = data_in;
    end

    // Lane counter and assembly register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_r <= {LANE_W{1'b0}};
            asm_r  <= {OUT_W{1'b0}};
        end else if (complete_s) begin
            lane_r <= {LANE_W{1'b0}};
            asm_r  <= {OUT_W{1'b0}};
        end else if (accept_s) begin
            lane_r <= lane_r + LANE_W'(1);
            asm_r  <= word_s;
        end else begin
            lane_r <= lane_r;
            asm_r  <= asm_r;
        end
    end

    // Output word register: load on completion, drop valid once consumed, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= {OUT_W{1'b0}};
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            count_out <= {COUNT_W{1'b0}};
        end else if (complete_s) begin
            data_out  <= word_s;
            valid_out <= 1'b1;
            last_out  <= last_in;
            count_out <= COUNT_W'(lane_r) + COUNT_W'(1);
        end else if (ready_out) begin
            data_out  <= data_out;
            valid_out <= 1'b0;
            last_out  <= last_out;
            count_out <= count_out;
        end else begin
            data_out  <= data_out;
            valid_out <= valid_out;
            last_out  <= last_out;
            count_out <= count_out;
        end
    end

endmodule

// File: tb/tb_stream_deserializer.sv
// Directed self-checking bench for stream_deserializer (IN_WIDTH=8, RATIO=4).
module tb_stream_deserializer;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_in;
    logic        last_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_out;
    logic        last_out;
    logic [2:0]  count_out;

    int vectors;
    int miscompares;

    stream_deserializer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .last_in   (last_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_out  (last_out),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; valid_in = 1'b0; last_in = 1'b0; data_in = 8'h00; ready_out = 1'b1;
        @(negedge clk);
        vectors++;
        if ({valid_out, last_out, count_out, data_out} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b l=%b c=%0d d=%h required all zero", valid_out, last_out, count_out, data_out);
        end
        rst = 1'b1;
        tick;
        vectors++;
        if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_in: got rdy=%b v=%b required rdy=1 v=0", ready_in, valid_out);
        end
    endtask

    task automatic test_full_word;
        logic [7:0] b [4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            data_in = b[i]; valid_in = 1'b1; last_in = 1'b0;
            tick;
            if (i < 3) begin
                vectors++;
                if (valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_early_valid: beat %0d got valid_out=%b required 0", i, valid_out);
                end
            end
        end
        valid_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'h44332211 || count_out !== 3'd4 || last_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_word: got v=%b d=%h c=%0d l=%b required v=1 d=44332211 c=4 l=0", valid_out, data_out, count_out, last_out);
        end
        tick;
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_consumed: got valid_out=%b required 0", valid_out);
        end
    endtask

    task automatic test_last_flush;
        data_in = 8'hAA; valid_in = 1'b1; last_in = 1'b0;
        tick;
        data_in = 8'hBB; last_in = 1'b1;
        tick;
        valid_in = 1'b0; last_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'h0000BBAA || count_out !== 3'd2 || last_out !== 1'b1) begin
            miscompares++;
            $display("FAIL last_flush: got v=%b d=%h c=%0d l=%b required v=1 d=0000bbaa c=2 l=1", valid_out, data_out, count_out, last_out);
        end
        tick;
        data_in = 8'h5A; valid_in = 1'b1; last_in = 1'b1;
        tick;
        valid_in = 1'b0; last_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'h0000005A || count_out !== 3'd1 || last_out !== 1'b1) begin
            miscompares++;
            $display("FAIL single_flush: got v=%b d=%h c=%0d l=%b required v=1 d=0000005a c=1 l=1", valid_out, data_out, count_out, last_out);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_word;
        logic        exp_valid;
        int          words;
        words = 0;
        ready_out = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                exp_valid = ((i - 1) % 4 == 3);
                vectors++;
                if (valid_out !== exp_valid) begin
                    miscompares++;
                    $display("FAIL b2b_valid: slot %0d got valid_out=%b required %b", i, valid_out, exp_valid);
                end
                if (exp_valid) begin
                    for (int j = 0; j < 4; j++) exp_word[j*8 +: 8] = 8'(8'h10 + (i - 4 + j));
                    if (valid_out === 1'b1) words++;
                    vectors++;
                    if (data_out !== exp_word || count_out !== 3'd4 || last_out !== 1'b0) begin
                        miscompares++;
                        $display("FAIL b2b_word: slot %0d got d=%h c=%0d l=%b required d=%h c=4 l=0", i, data_out, count_out, last_out, exp_word);
                    end
                end
            end
            vectors++;
            if (ready_in !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready_in: slot %0d got ready_in=%b required 1", i, ready_in);
            end
            if (i < 16) begin
                data_in = 8'(8'h10 + i); valid_in = 1'b1; last_in = 1'b0;
            end else begin
                valid_in = 1'b0;
            end
            tick;
        end
        vectors++;
        if (words !== 4) begin
            miscompares++;
            $display("FAIL b2b_word_count: got %0d required 4", words);
        end
    endtask

    task automatic test_backpressure;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(8'hA0 + i); valid_in = 1'b1; last_in = 1'b0;
            tick;
        end
        ready_out = 1'b0;
        data_in = 8'hB0;
        #1;
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== 32'hA3A2A1A0 || count_out !== 3'd4) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got rdy=%b v=%b d=%h c=%0d required rdy=0 v=1 d=a3a2a1a0 c=4", c, ready_in, valid_out, data_out, count_out);
            end
            tick;
        end
        ready_out = 1'b1;
        #1;
        vectors++;
        if (ready_in !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready_in: got %b required 1", ready_in);
        end
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(8'hB0 + i); valid_in = 1'b1;
            tick;
            if (i < 3) begin
                vectors++;
                if (valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_gap_valid: beat %0d got valid_out=%b required 0", i, valid_out);
                end
            end
        end
        valid_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'hB3B2B1B0 || count_out !== 3'd4) begin
            miscompares++;
            $display("FAIL bp_next_word: got v=%b d=%h c=%0d required v=1 d=b3b2b1b0 c=4", valid_out, data_out, count_out);
        end
        tick;
    endtask

    task automatic test_no_bubble;
        ready_out = 1'b1;
        data_in = 8'hC1; valid_in = 1'b1; last_in = 1'b1;
        tick;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'h000000C1 || count_out !== 3'd1) begin
            miscompares++;
            $display("FAIL nb_first: got v=%b d=%h c=%0d required v=1 d=000000c1 c=1", valid_out, data_out, count_out);
        end
        data_in = 8'hC2;
        tick;
        valid_in = 1'b0; last_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'h000000C2 || last_out !== 1'b1) begin
            miscompares++;
            $display("FAIL nb_second: got v=%b d=%h l=%b required v=1 d=000000c2 l=1", valid_out, data_out, last_out);
        end
        tick;
    endtask

    task automatic test_reset_midrow;
        ready_out = 1'b1;
        data_in = 8'hEE; valid_in = 1'b1; last_in = 1'b0;
        tick;
        data_in = 8'hEF;
        tick;
        valid_in = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL midrow_async: got v=%b d=%h required v=0 d=00000000", valid_out, data_out);
        end
        tick;
        rst = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(8'h01 + i); valid_in = 1'b1;
            tick;
            if (i < 3) begin
                vectors++;
                if (valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrow_stale: beat %0d got valid_out=%b d=%h required 0", i, valid_out, data_out);
                end
            end
        end
        valid_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || data_out !== 32'h04030201 || count_out !== 3'd4) begin
            miscompares++;
            $display("FAIL midrow_word: got v=%b d=%h c=%0d required v=1 d=04030201 c=4", valid_out, data_out, count_out);
        end
        tick;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_full_word;
        test_last_flush;
        test_back_to_back;
        test_backpressure;
        test_no_bubble;
        test_reset_midrow;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
